// File: rtl/mul_operand_feeder.sv
// mul_operand_feeder
//   Buffers {a,b} operand pairs in a small FIFO and sequences them onto a
//   shared operand bus for a decrement-style multiplier: a one-cycle start
//   pulse, the larger operand X for two cycles, then the smaller operand Y
//   held until the multiplier reports done.
//
// Ports
//   clk       sole clock, rising edge
//   rst_n     synchronous active-low reset
//   in_valid  upstream offers {in_a,in_b}
//   in_ready  FIFO not full (registered)
//   in_a      multiplicand offered (16 bit)
//   in_b      multiplier offered (16 bit)
//   start     one-cycle start pulse to the multiplier control
//   data      operand bus (16 bit)
//   done      multiplier finished (level, only honoured while waiting)
//   busy      a multiply is in flight
//   pair_cnt  completed multiplies, wraps 255 -> 0
//   err       one-cycle watchdog-abort pulse
//
// Configuration
//   MUL_FEEDER_TIMEOUT_EN  when defined, a watchdog aborts a WAIT that lasts
//                          TMO_CYCLES cycles; otherwise err is constant 0.
module mul_operand_feeder #(
  parameter int DEPTH      = 4,
  parameter int TMO_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        start,
  output logic [15:0] data,
  input  logic        done,
  output logic        busy,
  output logic [7:0]  pair_cnt,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Reject unsupported configurations at elaboration.
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mul_operand_feeder: DEPTH must be a power of 2 in 2..16");
  end
  if (TMO_CYCLES < 1) begin : g_bad_tmo
    $error("mul_operand_feeder: TMO_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    LDA   = 3'd2,
    LDB   = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t         state_r;
  logic [31:0]    mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic [CW-1:0]  count_nxt_s;
  logic           push_s;
  logic           pop_s;
  logic [31:0]    head_s;
  logic [15:0]    x_nxt_s;
  logic [15:0]    y_nxt_s;
  logic [15:0]    x_r;
  logic [15:0]    y_r;
  logic           in_ready_r;
  logic           start_r;
  logic [15:0]    data_r;
  logic           busy_r;
  logic [7:0]     pair_cnt_r;
  logic           err_r;

`ifdef MUL_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  logic [TW-1:0]  wdog_r;
  logic           tmo_hit_s;

  assign tmo_hit_s = (wdog_r == TMO_LAST);
  // The head pair leaves the FIFO on completion or on a watchdog abort.
  assign pop_s     = (state_r == WAIT) && (done || tmo_hit_s);
`else
  // The head pair stays in the FIFO for the whole multiply; it leaves only on done.
  assign pop_s     = (state_r == WAIT) && done;
`endif

  assign push_s   = in_valid && in_ready_r;

  assign in_ready = in_ready_r;
  assign start    = start_r;
  assign data     = data_r;
  assign busy     = busy_r;
  assign pair_cnt = pair_cnt_r;
  assign err      = err_r;

  // Next FIFO occupancy from this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Order the head pair so X >= Y; fewer decrement iterations, same product.
  always_comb begin
    head_s  = mem_r[rd_ptr_r];
    x_nxt_s = head_s[31:16];
    y_nxt_s = head_s[15:0];
    if (head_s[15:0] > head_s[31:16]) begin
      x_nxt_s = head_s[15:0];
      y_nxt_s = head_s[31:16];
    end else begin
      x_nxt_s = head_s[31:16];
      y_nxt_s = head_s[15:0];
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_a, in_b};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_nxt_s;
      // Ready reflects the occupancy after this edge, so a pop while full
      // only reopens the input on the following cycle.
      in_ready_r <= (count_nxt_s != CNT_FULL);
    end
  end

  // Sequencing FSM with registered start/data/busy/pair_cnt/err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      x_r        <= 16'd0;
      y_r        <= 16'd0;
      start_r    <= 1'b0;
      data_r     <= 16'd0;
      busy_r     <= 1'b0;
      pair_cnt_r <= 8'd0;
      err_r      <= 1'b0;
`ifdef MUL_FEEDER_TIMEOUT_EN
      wdog_r     <= {TW{1'b0}};
`endif
    end else begin
      start_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (count_r != {CW{1'b0}}) begin
            state_r <= START;
            x_r     <= x_nxt_s;
            y_r     <= y_nxt_s;
            start_r <= 1'b1;
            data_r  <= x_nxt_s;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          state_r <= LDA;
          data_r  <= x_r;
        end
        LDA: begin
          state_r <= LDB;
          data_r  <= y_r;
        end
        LDB: begin
          state_r <= WAIT;
          data_r  <= y_r;
`ifdef MUL_FEEDER_TIMEOUT_EN
          wdog_r  <= {TW{1'b0}};
`endif
        end
        WAIT: begin
          if (done) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            pair_cnt_r <= pair_cnt_r + 8'd1;
          end
`ifdef MUL_FEEDER_TIMEOUT_EN
          else if (tmo_hit_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            err_r   <= 1'b1;
          end else begin
            wdog_r  <= wdog_r + TMO_ONE;
          end
`else
          else begin
            state_r <= WAIT;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Self-checking bench for mul_operand_feeder (DEPTH=4, TMO_CYCLES=1023).
// A table of operand pairs drives the main sequence; hand-written sequences
// cover back-to-back spacing, FIFO full, reset mid-operation and the
// watchdog. A negedge monitor pops an ordered-pair scoreboard on each start.
module tb_mul_operand_feeder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        start;
  logic [15:0] data;
  logic        done;
  logic        busy;
  logic [7:0]  pair_cnt;
  logic        err;

  mul_operand_feeder #(.DEPTH(4), .TMO_CYCLES(1023)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .start    (start),
    .data     (data),
    .done     (done),
    .busy     (busy),
    .pair_cnt (pair_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } pair_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] x;
    logic [15:0] y;
    bit          early_done;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  pair_t sb_q[$];
  vec_t  vecs[7];
  logic [7:0] exp_cnt;

  int    phase = 0;
  logic  prev_start = 1'b0;
  pair_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic pair_t order_pair(input logic [15:0] a, input logic [15:0] b);
    pair_t p;
    if (a >= b) begin
      p.x = a;
      p.y = b;
    end else begin
      p.x = b;
      p.y = a;
    end
    return p;
  endfunction

  // Offer one pair for one edge; scoreboard it if the DUT is ready.
  task automatic offer(input logic [15:0] a, input logic [15:0] b, output bit acc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    acc      = in_ready;
    if (acc) sb_q.push_back(order_pair(a, b));
    step();
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!start && n < 20) begin
      step();
      n++;
    end
    check("start_seen", 32'(start), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  // Monitor: every start consumes one scoreboard entry; check the bus phases.
  always @(negedge clk) begin
    if (!rst_n) begin
      phase      = 0;
      prev_start = 1'b0;
    end else begin
      if (start) begin
        check("start_single", 32'(prev_start), 32'd0);
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_start: got start with empty scoreboard");
          phase = 0;
        end else begin
          cur = sb_q.pop_front();
          check("mon_x_start", 32'(data), 32'(cur.x));
          phase = 1;
        end
      end else if (phase == 1) begin
        check("mon_x_lda", 32'(data), 32'(cur.x));
        phase = 2;
      end else if (phase == 2) begin
        check("mon_y_ldb", 32'(data), 32'(cur.y));
        phase = 3;
      end else if (phase == 3) begin
        check("mon_y_wait", 32'(data), 32'(cur.y));
        phase = 0;
      end
      prev_start = start;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit acc;
    int c1;
    int c2;
    int n;
    int err_hits;

    vecs[0] = '{16'd17,     16'd5,      16'd17,     16'd5,      1'b0};
    vecs[1] = '{16'd3,      16'd200,    16'd200,    16'd3,      1'b0};
    vecs[2] = '{16'd9,      16'd9,      16'd9,      16'd9,      1'b0};
    vecs[3] = '{16'd0,      16'h1234,   16'h1234,   16'd0,      1'b1};
    vecs[4] = '{16'hFFFF,   16'd1,      16'hFFFF,   16'd1,      1'b0};
    vecs[5] = '{16'd100,    16'd0,      16'd100,    16'd0,      1'b1};
    vecs[6] = '{16'h7FFF,   16'h8000,   16'h8000,   16'h7FFF,   1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_start",    32'(start),    32'd0);
    check("rst_data",     32'(data),     32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_pair_cnt", 32'(pair_cnt), 32'd0);
    check("rst_err",      32'(err),      32'd0);
    exp_cnt = 8'd0;

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++) begin
      check("vec_ready", 32'(in_ready), 32'd1);
      offer(vecs[i].a, vecs[i].b, acc);
      in_valid = 1'b0;
      wait_start();
      check("vec_x_start", 32'(data), 32'(vecs[i].x));
      check("vec_busy_start", 32'(busy), 32'd1);
      if (vecs[i].early_done) done = 1'b1;
      step();
      check("vec_start_low", 32'(start), 32'd0);
      check("vec_x_lda", 32'(data), 32'(vecs[i].x));
      step();
      done = 1'b0;
      check("vec_y_ldb", 32'(data), 32'(vecs[i].y));
      step();
      check("vec_y_wait", 32'(data), 32'(vecs[i].y));
      check("vec_busy_wait", 32'(busy), 32'd1);
      check("vec_cnt_wait", 32'(pair_cnt), 32'(exp_cnt));
      done = 1'b1;
      step();
      done = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      check("vec_busy_done", 32'(busy), 32'd0);
      check("vec_cnt_done", 32'(pair_cnt), 32'(exp_cnt));
    end

    // Back-to-back: start pulses 5 cycles apart with done held high.
    offer(16'd40, 16'd50, acc);
    offer(16'd7, 16'd6, acc);
    in_valid = 1'b0;
    done = 1'b1;
    wait_start();
    c1 = cyc;
    step();
    n = 0;
    while (!start && n < 20) begin
      step();
      n++;
    end
    check("b2b_second_start", 32'(start), 32'd1);
    c2 = cyc;
    check("b2b_spacing", 32'(c2 - c1), 32'd5);
    step();
    wait_idle();
    done = 1'b0;
    exp_cnt = exp_cnt + 8'd2;
    check("b2b_cnt", 32'(pair_cnt), 32'(exp_cnt));

    // FIFO full: 4 accepted, 5th refused until a done frees the head slot.
    for (int k = 0; k < 5; k++) begin
      check("full_ready_pattern", 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
      offer(16'(k * 11 + 2), 16'(k * 3 + 20), acc);
    end
    step(); step(); step();
    check("full_ready_held", 32'(in_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    check("full_ready_reopen", 32'(in_ready), 32'd1);
    acc = in_ready;
    if (acc) sb_q.push_back(order_pair(in_a, in_b));
    step();
    in_valid = 1'b0;
    done = 1'b1;
    n = 0;
    while (pair_cnt != 8'(exp_cnt + 8'd5) && n < 200) begin
      step();
      n++;
    end
    done = 1'b0;
    exp_cnt = exp_cnt + 8'd5;
    check("full_drain_cnt", 32'(pair_cnt), 32'(exp_cnt));
    step();
    check("full_drain_idle", 32'(busy), 32'd0);

    // Reset while waiting with 3 pairs queued behind the head.
    for (int k = 0; k < 4; k++) begin
      offer(16'(k + 60), 16'(k + 1), acc);
    end
    in_valid = 1'b0;
    step();
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    exp_cnt = 8'd0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_start", 32'(start), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_pair_cnt", 32'(pair_cnt), 32'd0);
    check("mid_data", 32'(data), 32'd0);
    done = 1'b1;
    for (int k = 0; k < 10; k++) step();
    done = 1'b0;
    check("mid_busy_after", 32'(busy), 32'd0);
    check("mid_cnt_after", 32'(pair_cnt), 32'd0);

    // Watchdog behaviour.
    offer(16'd12, 16'd34, acc);
    in_valid = 1'b0;
    wait_start();
    step(); step(); step();
    check("wd_in_wait", 32'(busy), 32'd1);
`ifdef MUL_FEEDER_TIMEOUT_EN
    n = 0;
    while (!err && n < 1100) begin
      step();
      n++;
    end
    check("wd_err_delay", 32'(n), 32'd1023);
    check("wd_busy", 32'(busy), 32'd0);
    check("wd_cnt", 32'(pair_cnt), 32'(exp_cnt));
    step();
    check("wd_err_pulse", 32'(err), 32'd0);
    check("wd_ready", 32'(in_ready), 32'd1);
`else
    err_hits = 0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (err) err_hits++;
    end
    check("wd_err_never", 32'(err_hits), 32'd0);
    check("wd_still_busy", 32'(busy), 32'd1);
    check("wd_cnt_hold", 32'(pair_cnt), 32'(exp_cnt));
    done = 1'b1;
    step();
    done = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("wd_cnt_done", 32'(pair_cnt), 32'(exp_cnt));
`endif

    step(); step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_operand_feeder.md
MUL_OPERAND_FEEDER -- requirements
Module: mul_operand_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand-pair FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter TMO_CYCLES, default 1023, done-watchdog limit in cycles (used only with REQ-030).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers an operand pair.
REQ-006 in_ready  output  1  feeder accepts a pair this cycle.
REQ-007 in_a  input  16  multiplicand offered.
REQ-008 in_b  input  16  multiplier offered.
REQ-009 start  output  1  one-cycle start pulse to the multiplier control.
REQ-010 data  output  16  operand bus to the multiplier datapath.
REQ-011 done  input  1  multiplier finished, level, sampled each cycle.
REQ-012 busy  output  1  a multiply is in flight (state other than IDLE).
REQ-013 pair_cnt  output  8  completed multiplies, wraps 255->0.
REQ-014 err  output  1  one-cycle watchdog-abort pulse (tied 0 without REQ-030).

Function
REQ-015 Pair accepted on a cycle with in_valid=1 and in_ready=1; in_ready = FIFO not full.
REQ-016 FIFO SHALL store {a,b} in order; head entry is popped only on leaving WAIT.
REQ-017 Simultaneous push and pop when full SHALL be allowed: in_ready stays 0 that cycle (registered full), occupancy unchanged next cycle after the pop frees a slot.
REQ-018 At head capture the feeder SHALL order operands: X = max(a,b), Y = min(a,b) (ties: X=a), minimising decrement iterations; product unchanged.
REQ-019 FSM states: IDLE, START, LDA, LDB, WAIT.
REQ-020 IDLE -> START when FIFO non-empty; X/Y registered on this transition.
REQ-021 START: start=1, data=X, one cycle, -> LDA.
REQ-022 LDA: start=0, data=X, one cycle, -> LDB.
REQ-023 LDB: data=Y, one cycle, -> WAIT.
REQ-024 WAIT: data=Y held; on done=1 pop FIFO, pair_cnt+1, -> IDLE; done seen in any other state SHALL be ignored.
REQ-025 Back-to-back: minimum spacing between successive start pulses is 5 cycles (START, LDA, LDB, WAIT with done, IDLE).
REQ-026 Y=0 SHALL still be issued unchanged; completion relies on done only.
REQ-027 start SHALL never be high for two consecutive cycles.

Reset
REQ-028 On clk edge with rst_n=0: state IDLE, FIFO empty, pointers 0, start=0, data=0, busy=0, pair_cnt=0, err=0, watchdog 0; in_ready=1 from the first cycle after reset.
REQ-029 Reset mid-operation (any state) SHALL discard the in-flight pair and all queued pairs; no pop, no count.

Configuration
REQ-030 Macro MUL_FEEDER_TIMEOUT_EN: when defined, a watchdog counts cycles in WAIT; on reaching TMO_CYCLES without done, pulse err=1 one cycle, pop head, leave pair_cnt unchanged, -> IDLE. Without the macro, no counter is built, WAIT is unbounded, err is constant 0.

Verification
REQ-031 in_a=17, in_b=5 pushed after reset -> start pulse 1 cycle, data=17 in START/LDA, data=5 in LDB/WAIT; done=1 -> pair_cnt=1, busy=0 next cycle.
REQ-032 in_a=3, in_b=200 -> data=200 in START/LDA, data=3 in LDB; in_a=9, in_b=9 -> data=9 both.
REQ-033 DEPTH=4, done held 0, push 5 pairs continuously -> 4 accepted (head in flight counts), in_ready=0 on the 5th; done pulse -> in_ready=1 the following cycle, 5th accepted.
REQ-034 rst_n=0 for one edge while in WAIT with 3 pairs queued -> next cycle busy=0, start=0, in_ready=1, pair_cnt=0; later done=1 ignored.
REQ-035 With MUL_FEEDER_TIMEOUT_EN, TMO_CYCLES=1023, done held 0 -> err=1 exactly 1023 cycles after WAIT entry, head popped, pair_cnt unchanged; without macro err stays 0 for 2000 cycles.
